// File: rtl/exc_req.sv
// Exception/interrupt request arbiter: prioritises MEM-stage exceptions, syscalls and
// synchronised external interrupts, issues one number per handler entry and tracks return.
module exc_req (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] exc_vec_i,
  input  logic        syscall_i,
  input  logic [15:0] int_i,
  input  logic [15:0] int_mask_i,
  input  logic [31:0] inst_pc_i,
  input  logic        eret_i,
  output logic [7:0]  exp_no_o,
  output logic [31:0] epc_o,
  output logic        in_handler_o,
  output logic [15:0] int_pend_o,
  output logic        dbl_fault_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    HANDLER = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] sync1;
  logic [15:0] sync2;
  logic [15:0] sync_d;
  logic [15:0] int_rise;
  logic [15:0] int_pend;
  logic [15:0] int_ready;
  logic [15:0] sel_clr;
  logic [15:0] int_clr;
  logic [7:0]  sel_no;
  logic        sel_valid;
  logic        take;
  logic [7:0]  exp_q;

  assign int_rise = sync2 & ~sync_d;

  // Fixed priority: lowest exception bit, then syscall, then lowest unmasked pending interrupt.
  always_comb begin
    sel_valid = 1'b0;
    sel_no    = '1;
    sel_clr   = '0;
    int_ready = int_pend & int_mask_i;
    for (int unsigned k = 0; k < 20; k++) begin
      if (!sel_valid && exc_vec_i[k]) begin
        sel_valid = 1'b1;
        sel_no    = 8'(k);
      end
    end
    if (!sel_valid && syscall_i) begin
      sel_valid = 1'b1;
      sel_no    = 8'h50;
    end
    for (int unsigned k = 0; k < 16; k++) begin
      if (!sel_valid && int_ready[k]) begin
        sel_valid  = 1'b1;
        sel_no     = 8'(32 + k);
        sel_clr[k] = 1'b1;
      end
    end
  end

  assign take    = (state == IDLE) && sel_valid;
  assign int_clr = take ? sel_clr : '0;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (sel_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = HANDLER;
      HANDLER: if (eret_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= '0;
      sync2    <= '0;
      sync_d   <= '0;
      int_pend <= '0;
    end else begin
      sync1    <= int_i;
      sync2    <= sync1;
      sync_d   <= sync2;
      // A new edge wins over a clear on the same bit.
      int_pend <= (int_pend & ~int_clr) | int_rise;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      exp_q       <= '1;
      epc_o       <= '0;
      dbl_fault_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        exp_q <= sel_no;
        epc_o <= inst_pc_i;
      end
      if ((state != IDLE) && ((|exc_vec_i) || syscall_i)) dbl_fault_o <= 1'b1;
    end
  end

  assign exp_no_o     = (state == ISSUE) ? exp_q : 8'hFF;
  assign in_handler_o = (state != IDLE);
  assign int_pend_o   = int_pend;

endmodule

// File: tb/tb_exc_req.sv
// Directed bench for exc_req: expected exception numbers are queued at stimulus time and
// popped whenever the DUT shows a non-idle exp_no_o.
module tb_exc_req;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] exc_vec_i;
  logic        syscall_i;
  logic [15:0] int_i;
  logic [15:0] int_mask_i;
  logic [31:0] inst_pc_i;
  logic        eret_i;
  logic [7:0]  exp_no_o;
  logic [31:0] epc_o;
  logic        in_handler_o;
  logic [15:0] int_pend_o;
  logic        dbl_fault_o;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  logic [7:0]  exp_q[$];

  exc_req dut (
    .clk          (clk),
    .rst          (rst),
    .exc_vec_i    (exc_vec_i),
    .syscall_i    (syscall_i),
    .int_i        (int_i),
    .int_mask_i   (int_mask_i),
    .inst_pc_i    (inst_pc_i),
    .eret_i       (eret_i),
    .exp_no_o     (exp_no_o),
    .epc_o        (epc_o),
    .in_handler_o (in_handler_o),
    .int_pend_o   (int_pend_o),
    .dbl_fault_o  (dbl_fault_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock edge, then sample 1 time unit later and score any issued number.
  task automatic step();
    logic [7:0] want;
    @(posedge clk);
    #1;
    if (exp_no_o !== 8'hFF) begin
      if (exp_q.size() == 0) check("unexpected_issue", {24'h0, exp_no_o}, 32'h0000_00FF);
      else begin
        want = exp_q.pop_front();
        check("exp_no", {24'h0, exp_no_o}, {24'h0, want});
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_exp"},  {24'h0, exp_no_o},   32'h0000_00FF);
    check({tag, "_epc"},  epc_o,               32'h0);
    check({tag, "_inh"},  {31'h0, in_handler_o}, 32'h0);
    check({tag, "_pend"}, {16'h0, int_pend_o}, 32'h0);
    check({tag, "_dbl"},  {31'h0, dbl_fault_o}, 32'h0);
  endtask

  initial begin
    rst = 1'b0; exc_vec_i = '0; syscall_i = 1'b0; int_i = '0;
    int_mask_i = '1; inst_pc_i = '0; eret_i = 1'b0;
    step(); step();
    check_reset_vals("reset");
    rst = 1'b1;

    // Single exception, accepted on the first edge after release
    exc_vec_i = 20'h00010; inst_pc_i = 32'h100; exp_q.push_back(8'h04);
    step();
    exc_vec_i = '0; inst_pc_i = 32'h0;
    check("s1_epc", epc_o, 32'h100);
    check("s1_inh_issue", {31'h0, in_handler_o}, 32'h1);
    step();
    check("s1_inh_handler", {31'h0, in_handler_o}, 32'h1);
    eret_i = 1'b1;
    step();
    eret_i = 1'b0;
    check("s1_inh_ret", {31'h0, in_handler_o}, 32'h0);

    // Priority: exception beats syscall beats pending interrupt
    int_mask_i = 16'h0000; int_i = 16'h0001;
    repeat (4) step();
    check("s2_pend0", {16'h0, int_pend_o}, 32'h1);
    exc_vec_i = 20'h80000; syscall_i = 1'b1; int_mask_i = '1; inst_pc_i = 32'h180;
    exp_q.push_back(8'h13);
    step();
    exc_vec_i = '0; syscall_i = 1'b0;
    check("s2_pend_kept", {16'h0, int_pend_o}, 32'h1);
    step();
    eret_i = 1'b1; exp_q.push_back(8'h20);
    step();
    eret_i = 1'b0;
    step();
    check("s2_pend_cleared", {16'h0, int_pend_o}, 32'h0);
    step();
    eret_i = 1'b1; step(); eret_i = 1'b0;
    check("s2_no_dbl", {31'h0, dbl_fault_o}, 32'h0);

    // Interrupt latency through the synchroniser
    int_i = 16'h0009;
    step(); step();
    check("s3_pend_early", {16'h0, int_pend_o}, 32'h0);
    step();
    check("s3_pend_set", {16'h0, int_pend_o}, 32'h8);
    exp_q.push_back(8'h23);
    step();
    check("s3_pend_clr", {16'h0, int_pend_o}, 32'h0);
    step();
    eret_i = 1'b1; step(); eret_i = 1'b0;

    // Masked interrupt waits until unmasked
    int_mask_i = 16'hFFDF; int_i = 16'h0029;
    repeat (20) step();
    check("s4_pend_masked", {16'h0, int_pend_o}, 32'h20);
    check("s4_idle", {31'h0, in_handler_o}, 32'h0);
    int_mask_i = '1; exp_q.push_back(8'h25);
    step();
    check("s4_pend_clr", {16'h0, int_pend_o}, 32'h0);
    step();
    eret_i = 1'b1; step(); eret_i = 1'b0;

    // Nested exception dropped; interrupt raised in handler served after return
    exc_vec_i = 20'h00001; inst_pc_i = 32'h200; exp_q.push_back(8'h00);
    step();
    exc_vec_i = '0; inst_pc_i = 32'h300;
    step();
    exc_vec_i = 20'h00001;
    step();
    exc_vec_i = '0;
    check("s5_dbl", {31'h0, dbl_fault_o}, 32'h1);
    check("s5_epc", epc_o, 32'h200);
    int_i = 16'h002B;
    repeat (3) step();
    check("s5_pend1", {16'h0, int_pend_o}, 32'h2);
    check("s5_inh", {31'h0, in_handler_o}, 32'h1);
    eret_i = 1'b1; exp_q.push_back(8'h21);
    step();
    eret_i = 1'b0;
    step();
    check("s5_pend_clr", {16'h0, int_pend_o}, 32'h0);
    step();

    // Reset while in handler with two interrupts pending
    int_i = 16'h0028; step();
    int_i = 16'h002B;
    repeat (3) step();
    check("s6_pend", {16'h0, int_pend_o}, 32'h3);
    check("s6_inh", {31'h0, in_handler_o}, 32'h1);
    rst = 1'b0;
    #1;
    check_reset_vals("s6_async");
    int_i = '0;
    step(); step();
    rst = 1'b1;
    repeat (10) step();
    check("s6_idle", {31'h0, in_handler_o}, 32'h0);
    check("s6_no_pend", {16'h0, int_pend_o}, 32'h0);
    check("s6_dbl_cleared", {31'h0, dbl_fault_o}, 32'h0);
    check("queue_drained", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
